// File: rtl/uart_rx_deser_if.sv
// Byte hand-off between the UART receiver and its downstream consumer.
// The producer holds rx_data stable while rx_valid is high until it sees rx_ready.
interface uart_rx_deser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive front end: synchronises and oversamples uart_rxd, deserialises each frame
// mid-bit, and presents the bytes through a one-entry holding register.
module uart_rx_deser #(
  parameter int unsigned CLOCK_FREQ = 10_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic            bb_clk_in,
  input  logic            rst,
  input  logic            uart_rxd,
  uart_rx_deser_if.master rx_if,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  localparam int unsigned DIV  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] DivLast  = CntW'(DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sr_q, sr_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rxd_meta_q, rxd_s_q;
  logic            deliver;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge bb_clk_in or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge bb_clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      sr_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (!rxd_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          sr_d  = {rxd_s_q, sr_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBrk;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBrk: begin
        // Wait out a held-low line so a break cannot look like a new start bit.
        if (rxd_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_if.rx_ready) begin
        rx_data_d  = sr_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != StIdle);

endmodule
